// File: rtl/spi_pkg.sv
// Shared types for the multi-mode SPI master.
//   spi_state_t  : controller FSM states
//   spi_cfg_t    : per-transfer mode bits latched on accept
//   ss_idx_width : width of the binary slave-select index
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_cfg_t;

  // Index width for ss_select; a single slave still gets a 1-bit index.
  function automatic int unsigned ss_idx_width(input int unsigned ss_width);
    return (ss_width > 1) ? int'($clog2(ss_width)) : 1;
  endfunction

endpackage

// File: rtl/spi_master_multimode_if.sv
// Request/handshake bundle for spi_master_multimode.
//   master modport : requester drives start, tx_data, ss_select and mode/divider
//   slave modport  : controller returns busy, done and rx_data
interface spi_master_multimode_if #(
  parameter int unsigned word_width = 8,
  parameter int unsigned SS_width   = 1,
  parameter int unsigned div_width  = 8
);
  import spi_pkg::*;

  localparam int unsigned SS_idx_width = ss_idx_width(SS_width);

  logic                    start;
  logic [word_width-1:0]   tx_data;
  logic [SS_idx_width-1:0] ss_select;
  logic                    cpol;
  logic                    cpha;
  logic                    lsb_first;
  logic [div_width-1:0]    divider;
  logic                    busy;
  logic                    done;
  logic [word_width-1:0]   rx_data;

  modport master (
    output start, tx_data, ss_select, cpol, cpha, lsb_first, divider,
    input  busy, done, rx_data
  );

  modport slave (
    input  start, tx_data, ss_select, cpol, cpha, lsb_first, divider,
    output busy, done, rx_data
  );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period tick generator for the SPI master.
//   clk, rst_n : system clock, async active-low reset
//   en, clr    : count while en, restart from zero on clr
//   divider    : half-period is divider+1 clk cycles
//   cpol, sclk : current idle level and serial clock, to classify the tick
//   tick_c     : last cycle of a half-period
//   lead_c     : tick that takes sclk away from cpol
//   trail_c    : tick that returns sclk to cpol
module spi_clk_gen #(
  parameter int unsigned div_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [div_width-1:0] divider,
  input  logic                 cpol,
  input  logic                 sclk,
  output logic                 tick_c,
  output logic                 lead_c,
  output logic                 trail_c
);

  logic [div_width-1:0] cnt;

  // Counter wraps at divider, so it never exceeds the divider value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + div_width'(1);
    end
  end

  assign tick_c  = en && (cnt == divider);
  assign lead_c  = tick_c && (sclk == cpol);
  assign trail_c = tick_c && (sclk != cpol);

endmodule

// File: rtl/spi_master_multimode.sv
// Single-master SPI controller with runtime CPOL/CPHA, bit order and divider.
//   clk, rst_n : system clock, async active-low reset
//   bus        : start/tx_data/ss_select/mode/divider in, busy/done/rx_data out
//   sclk, mosi : serial clock and data out
//   miso       : serial data in, sampled on clk at the sample edge
//   ss_n       : active-low slave selects, at most one low
module spi_master_multimode
  import spi_pkg::*;
#(
  parameter int unsigned word_width = 8,
  parameter int unsigned SS_width   = 1,
  parameter int unsigned div_width  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_master_multimode_if.slave  bus,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic [SS_width-1:0]    ss_n
);

  localparam int unsigned SS_idx_width = ss_idx_width(SS_width);
  localparam int unsigned CNT_W        = $clog2(word_width) + 1;

  spi_state_t             state_q, state_d;
  spi_cfg_t               cfg_q, cfg_d;
  logic [div_width-1:0]   div_q, div_d;
  logic [word_width-1:0]  tx_q, tx_d;
  logic [word_width-1:0]  rx_q, rx_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [word_width-1:0]  rx_data_q, rx_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sclk_d, mosi_d;
  logic [SS_width-1:0]    ss_n_d;
  logic                   accept_c;
  logic                   tick_c, lead_c, trail_c;

  function automatic logic head(input logic [word_width-1:0] w, input logic lsb);
    return lsb ? w[0] : w[word_width-1];
  endfunction

  function automatic logic [word_width-1:0] shift_out(input logic [word_width-1:0] w,
                                                      input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Received bits are assembled in the same order they were shifted.
  function automatic logic [word_width-1:0] shift_in(input logic [word_width-1:0] w,
                                                     input logic b, input logic lsb);
    return lsb ? {b, w[word_width-1:1]} : {w[word_width-2:0], b};
  endfunction

  spi_clk_gen #(.div_width(div_width)) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != IDLE),
    .clr     (accept_c),
    .divider (div_q),
    .cpol    (cfg_q.cpol),
    .sclk    (sclk),
    .tick_c  (tick_c),
    .lead_c  (lead_c),
    .trail_c (trail_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    div_d     = div_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk;
    mosi_d    = mosi;
    ss_n_d    = ss_n;
    accept_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d = bus.cpol;
        mosi_d = 1'b0;
        ss_n_d = '1;
        if (bus.start) begin
          accept_c  = 1'b1;
          state_d   = SETUP;
          busy_d    = 1'b1;
          cfg_d     = '{cpol: bus.cpol, cpha: bus.cpha, lsb_first: bus.lsb_first};
          div_d     = bus.divider;
          bit_cnt_d = '0;
          rx_d      = '0;
          // An out-of-range index matches no line, so all selects stay high.
          for (int i = 0; i < int'(SS_width); i++) begin
            if (bus.ss_select == SS_idx_width'(i)) ss_n_d[i] = 1'b0;
          end
          // cpha=0 presents the first bit before the first leading edge.
          if (bus.cpha) begin
            tx_d = bus.tx_data;
          end else begin
            mosi_d = head(bus.tx_data, bus.lsb_first);
            tx_d   = shift_out(bus.tx_data, bus.lsb_first);
          end
        end
      end

      SETUP: begin
        if (tick_c) state_d = TRANSFER;
      end

      TRANSFER: begin
        if (tick_c) sclk_d = ~sclk;
        if (lead_c) begin
          if (cfg_q.cpha) begin
            mosi_d = head(tx_q, cfg_q.lsb_first);
            tx_d   = shift_out(tx_q, cfg_q.lsb_first);
          end else begin
            rx_d      = shift_in(rx_q, miso, cfg_q.lsb_first);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (trail_c) begin
          if (cfg_q.cpha) begin
            rx_d      = shift_in(rx_q, miso, cfg_q.lsb_first);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(word_width - 1)) state_d = HOLD;
          end else if (bit_cnt_q == CNT_W'(word_width)) begin
            state_d = HOLD;
          end else begin
            mosi_d = head(tx_q, cfg_q.lsb_first);
            tx_d   = shift_out(tx_q, cfg_q.lsb_first);
          end
        end
      end

      HOLD: begin
        if (tick_c) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
          ss_n_d    = '1;
          mosi_d    = 1'b0;
          sclk_d    = cfg_q.cpol;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      div_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= '1;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
      ss_n      <= ss_n_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule
